// File: rtl/ascon_round_ctrl.sv
// Round/phase sequencer for an ASCON-128a permutation_xor datapath (single AD block, N PT blocks).
// Optional stall watchdog in WAIT_AD/WAIT_PT is enabled by defining ASCON_TIMEOUT_EN.
module ascon_round_ctrl (
  input  logic       clock_i,
  input  logic       reset_i,
  input  logic       start_i,
  input  logic       data_valid_i,
  input  logic       last_i,
  output logic       data_ready_o,
  output logic       enable_o,
  output logic       input_mode_o,
  output logic       bypass_xor_end_o,
  output logic       en_xor_begin_key_o,
  output logic       en_xor_begin_data_o,
  output logic       mode_xor_key_o,
  output logic [3:0] round_o,
  output logic       cipher_valid_o,
  output logic       tag_valid_o,
  output logic       busy_o,
  output logic       error_o
);

  localparam int unsigned RND_W = 4;
  localparam logic [RND_W-1:0] RND_FIRST = RND_W'(0);
  localparam logic [RND_W-1:0] RND_DATA  = RND_W'(4);
  localparam logic [RND_W-1:0] RND_LAST  = RND_W'(11);

  typedef enum logic [2:0] {
    S_IDLE, S_INIT, S_WAIT_AD, S_AD, S_WAIT_PT, S_PT, S_FINAL, S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [RND_W-1:0] rnd_q, rnd_d;
  logic             waiting_c;
  logic             xfer_c;
  logic             timeout_c;

  assign waiting_c = (state_q == S_WAIT_AD) || (state_q == S_WAIT_PT);
  assign xfer_c    = waiting_c && data_valid_i;

`ifdef ASCON_TIMEOUT_EN
  localparam int unsigned TO_W = 8;
  localparam logic [TO_W-1:0] TO_MAX = '1;

  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            err_q;

  // Counts idle wait cycles; clears on transfer or on leaving the wait states.
  always_comb begin
    to_cnt_d  = '0;
    timeout_c = 1'b0;
    if (waiting_c && !xfer_c) begin
      if (to_cnt_q == TO_MAX) begin
        timeout_c = 1'b1;
      end else begin
        to_cnt_d = to_cnt_q + TO_W'(1);
      end
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      to_cnt_q <= '0;
      err_q    <= 1'b0;
    end else begin
      to_cnt_q <= to_cnt_d;
      err_q    <= timeout_c;
    end
  end

  assign error_o = err_q;
`else
  assign timeout_c = 1'b0;
  assign error_o   = 1'b0;
`endif

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      rnd_q   <= RND_FIRST;
    end else begin
      state_q <= state_d;
      rnd_q   <= rnd_d;
    end
  end

  // Next-state and round counter
  always_comb begin
    state_d = state_q;
    rnd_d   = rnd_q;
    case (state_q)
      S_IDLE: begin
        rnd_d = RND_FIRST;
        if (start_i) state_d = S_INIT;
      end
      S_INIT: begin
        rnd_d = rnd_q + RND_W'(1);
        if (rnd_q == RND_LAST) state_d = S_WAIT_AD;
      end
      S_WAIT_AD: begin
        if (timeout_c) begin
          state_d = S_IDLE;
          rnd_d   = RND_FIRST;
        end else if (data_valid_i) begin
          state_d = S_AD;
          rnd_d   = RND_DATA;
        end
      end
      S_AD: begin
        rnd_d = rnd_q + RND_W'(1);
        if (rnd_q == RND_LAST) state_d = S_WAIT_PT;
      end
      S_WAIT_PT: begin
        if (timeout_c) begin
          state_d = S_IDLE;
          rnd_d   = RND_FIRST;
        end else if (data_valid_i) begin
          if (last_i) begin
            state_d = S_FINAL;
            rnd_d   = RND_FIRST;
          end else begin
            state_d = S_PT;
            rnd_d   = RND_DATA;
          end
        end
      end
      S_PT: begin
        rnd_d = rnd_q + RND_W'(1);
        if (rnd_q == RND_LAST) state_d = S_WAIT_PT;
      end
      S_FINAL: begin
        rnd_d = rnd_q + RND_W'(1);
        if (rnd_q == RND_LAST) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
        rnd_d   = RND_FIRST;
      end
      default: begin
        state_d = S_IDLE;
        rnd_d   = RND_FIRST;
      end
    endcase
  end

  // Moore output decode from state_q/rnd_q only
  always_comb begin
    data_ready_o        = 1'b0;
    enable_o            = 1'b0;
    input_mode_o        = 1'b0;
    bypass_xor_end_o    = 1'b1;
    en_xor_begin_key_o  = 1'b0;
    en_xor_begin_data_o = 1'b0;
    mode_xor_key_o      = 1'b0;
    cipher_valid_o      = 1'b0;
    tag_valid_o         = 1'b0;
    busy_o              = (state_q != S_IDLE);
    case (state_q)
      S_INIT: begin
        enable_o     = 1'b1;
        input_mode_o = (rnd_q != RND_FIRST);
        if (rnd_q == RND_LAST) bypass_xor_end_o = 1'b0;
      end
      S_WAIT_AD, S_WAIT_PT: data_ready_o = 1'b1;
      S_AD: begin
        enable_o     = 1'b1;
        input_mode_o = 1'b1;
        if (rnd_q == RND_DATA) en_xor_begin_data_o = 1'b1;
        if (rnd_q == RND_LAST) begin
          bypass_xor_end_o = 1'b0;
          mode_xor_key_o   = 1'b1;
        end
      end
      S_PT: begin
        enable_o     = 1'b1;
        input_mode_o = 1'b1;
        if (rnd_q == RND_DATA) begin
          en_xor_begin_data_o = 1'b1;
          cipher_valid_o      = 1'b1;
        end
      end
      S_FINAL: begin
        enable_o     = 1'b1;
        input_mode_o = 1'b1;
        if (rnd_q == RND_FIRST) begin
          en_xor_begin_data_o = 1'b1;
          en_xor_begin_key_o  = 1'b1;
          cipher_valid_o      = 1'b1;
        end
        if (rnd_q == RND_LAST) bypass_xor_end_o = 1'b0;
      end
      S_DONE: tag_valid_o = 1'b1;
      default: ;
    endcase
  end

  assign round_o = rnd_q;

endmodule

// File: tb/tb_ascon_round_ctrl.sv
// Table-driven scoreboard bench for ascon_round_ctrl; honours ASCON_TIMEOUT_EN when defined.
module tb_ascon_round_ctrl;

  logic       clk = 1'b0;
  logic       reset_i, start_i, data_valid_i, last_i;
  logic       data_ready_o, enable_o, input_mode_o, bypass_xor_end_o;
  logic       en_xor_begin_key_o, en_xor_begin_data_o, mode_xor_key_o;
  logic [3:0] round_o;
  logic       cipher_valid_o, tag_valid_o, busy_o, error_o;

  always #5 clk = ~clk;

  ascon_round_ctrl dut (
    .clock_i             (clk),
    .reset_i             (reset_i),
    .start_i             (start_i),
    .data_valid_i        (data_valid_i),
    .last_i              (last_i),
    .data_ready_o        (data_ready_o),
    .enable_o            (enable_o),
    .input_mode_o        (input_mode_o),
    .bypass_xor_end_o    (bypass_xor_end_o),
    .en_xor_begin_key_o  (en_xor_begin_key_o),
    .en_xor_begin_data_o (en_xor_begin_data_o),
    .mode_xor_key_o      (mode_xor_key_o),
    .round_o             (round_o),
    .cipher_valid_o      (cipher_valid_o),
    .tag_valid_o         (tag_valid_o),
    .busy_o              (busy_o),
    .error_o             (error_o)
  );

  typedef struct packed {
    logic       rdy, en, im, byp, ek, ed, mk;
    logic [3:0] rnd;
    logic       cv, tv, busy, err;
  } obs_t;

  typedef struct {
    logic  rst, start, dv, last;
    obs_t  exp;
    obs_t  mask;
    string name;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic obs_t mk(input logic rdy, en, im, byp, ek, ed, mkk,
                              input logic [3:0] rnd, input logic cv, tv, busy, err);
    obs_t o;
    o = '{rdy:rdy, en:en, im:im, byp:byp, ek:ek, ed:ed, mk:mkk, rnd:rnd,
          cv:cv, tv:tv, busy:busy, err:err};
    return o;
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o = {data_ready_o, enable_o, input_mode_o, bypass_xor_end_o, en_xor_begin_key_o,
         en_xor_begin_data_o, mode_xor_key_o, round_o, cipher_valid_o, tag_valid_o,
         busy_o, error_o};
    return o;
  endfunction

  function automatic obs_t full_mask(input logic rnd_care);
    obs_t m;
    m = '1;
    if (!rnd_care) m.rnd = 4'h0;
    return m;
  endfunction

  task automatic check(input obs_t e, input obs_t m, input string nm);
    logic [14:0] a;
    a = sample();
    n_vec++;
    if ((a & m) !== (e & m)) begin
      n_err++;
      $display("FAIL %s: got %h want %h (mask %h)", nm, a & m, e & m, m);
    end
  endtask

  task automatic add(input logic rst, st, dv, lst, input obs_t e, input logic rnd_care,
                     input string nm);
    vec_t v;
    v = '{rst:rst, start:st, dv:dv, last:lst, exp:e, mask:full_mask(rnd_care), name:nm};
    vecs.push_back(v);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive each vector, queue its expectation, compare after the edge
  task automatic run_table();
    vec_t e;
    foreach (vecs[i]) begin
      reset_i      = vecs[i].rst;
      start_i      = vecs[i].start;
      data_valid_i = vecs[i].dv;
      last_i       = vecs[i].last;
      exp_q.push_back(vecs[i]);
      tick();
      e = exp_q.pop_front();
      check(e.exp, e.mask, e.name);
    end
    vecs.delete();
    reset_i = 1'b0; start_i = 1'b0; data_valid_i = 1'b0; last_i = 1'b0;
  endtask

  obs_t o_idle, o_wait, o_done;

  task automatic add_init(input string tag);
    add(0, 1, 0, 0, mk(0,1,0,1,0,0,0,4'd0,0,0,1,0), 1, $sformatf("%s_init_r0", tag));
    for (int r = 1; r <= 11; r++)
      add(0, 0, 0, 0, mk(0,1,1,(r != 11),0,0,0,4'(r),0,0,1,0), 1,
          $sformatf("%s_init_r%0d", tag, r));
    add(0, 0, 0, 0, o_wait, 0, $sformatf("%s_wait_ad", tag));
  endtask

  initial begin
    logic [3:0] hold_rnd;
    int         hit;
    logic       ok;

    o_idle = mk(0,0,0,1,0,0,0,4'd0,0,0,0,0);
    o_wait = mk(1,0,0,1,0,0,0,4'd0,0,0,1,0);
    o_done = mk(0,0,0,1,0,0,0,4'd0,0,1,1,0);

    reset_i = 1'b1; start_i = 1'b0; data_valid_i = 1'b0; last_i = 1'b0;
    tick(); tick();
    check(o_idle, full_mask(1), "reset_idle");
    reset_i = 1'b0;
    tick();
    check(o_idle, full_mask(1), "idle_hold");

    // INIT, AD block, one non-last PT block
    add_init("enc");
    for (int i = 0; i < 3; i++)
      add(0, 1, 0, 0, o_wait, 0, $sformatf("wait_ad_start_ign%0d", i));
    add(0, 0, 1, 0, mk(0,1,1,1,0,1,0,4'd4,0,0,1,0), 1, "ad_r4");
    for (int r = 5; r <= 11; r++)
      add(0, 0, 0, 0, mk(0,1,1,(r != 11),0,0,(r == 11),4'(r),0,0,1,0), 1,
          $sformatf("ad_r%0d", r));
    add(0, 0, 0, 0, o_wait, 0, "wait_pt0");
    add(0, 0, 1, 0, mk(0,1,1,1,0,1,0,4'd4,1,0,1,0), 1, "pt_r4");
    for (int r = 5; r <= 11; r++)
      add(0, 0, 0, 0, mk(0,1,1,1,0,0,0,4'(r),0,0,1,0), 1, $sformatf("pt_r%0d", r));
    add(0, 0, 0, 0, o_wait, 0, "wait_pt1");
    run_table();

    // Stall in WAIT_PT for 20 cycles with start pulses
    hold_rnd = round_o;
    ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      start_i = 1'(i % 2);
      tick();
      if (enable_o !== 1'b0 || data_ready_o !== 1'b1 || busy_o !== 1'b1 ||
          round_o !== hold_rnd || error_o !== 1'b0)
        ok = 1'b0;
    end
    start_i = 1'b0;
    n_vec++;
    if (!ok) begin
      n_err++;
      $display("FAIL wait_pt_stall: got rnd %0d en %b rdy %b want constant rnd, en 0, rdy 1",
               round_o, enable_o, data_ready_o);
    end

    // Last PT block -> FINAL, DONE, IDLE
    add(0, 0, 1, 1, mk(0,1,1,1,1,1,0,4'd0,1,0,1,0), 1, "final_r0");
    for (int r = 1; r <= 11; r++)
      add(0, 0, 0, 0, mk(0,1,1,(r != 11),0,0,0,4'(r),0,0,1,0), 1, $sformatf("final_r%0d", r));
    add(0, 0, 0, 0, o_done, 0, "done_tag");
    add(0, 1, 0, 0, o_idle, 1, "after_done_idle");
    run_table();
    tick();

    // Reset during INIT round 6
    add(0, 1, 0, 0, mk(0,1,0,1,0,0,0,4'd0,0,0,1,0), 1, "rst_init_r0");
    for (int r = 1; r <= 6; r++)
      add(0, 0, 0, 0, mk(0,1,1,1,0,0,0,4'(r),0,0,1,0), 1, $sformatf("rst_init_r%0d", r));
    add(1, 0, 0, 0, o_idle, 1, "rst_mid_init");
    add(0, 0, 0, 0, o_idle, 1, "rst_after_idle");
    run_table();

    // Starvation in WAIT_AD
    add_init("to");
    run_table();
`ifdef ASCON_TIMEOUT_EN
    hit = -1;
    for (int i = 1; i <= 300 && hit < 0; i++) begin
      tick();
      if (error_o === 1'b1) hit = i;
    end
    n_vec++;
    if (hit != 256) begin
      n_err++;
      $display("FAIL timeout_cycle: got %0d want 256", hit);
    end
    check(mk(0,0,0,1,0,0,0,4'd0,0,0,0,1), full_mask(1), "timeout_idle_err");
    tick();
    check(o_idle, full_mask(1), "timeout_err_single");
`else
    hit = 0;
    ok  = 1'b1;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (data_ready_o !== 1'b1 || busy_o !== 1'b1 || error_o !== 1'b0) ok = 1'b0;
    end
    n_vec++;
    if (!ok) begin
      n_err++;
      $display("FAIL no_timeout_wait: got rdy %b busy %b err %b want 1 1 0",
               data_ready_o, busy_o, error_o);
    end
    check(o_wait, full_mask(0), "no_timeout_final");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
